// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit:
// parameter defaults, the regfile forward-select code and tracker field widths.
package hazard_forward_unit_pkg;

   // Default register address width (RV32: 32 architectural registers).
   localparam int DEF_REG_AW     = 5;
   // Default number of source operands per instruction.
   localparam int DEF_NUM_SRC    = 2;
   // Default number of post-EX stages able to forward.
   localparam int DEF_FWD_STAGES = 2;
   // Default number of slots after EX before load data is forwardable.
   localparam int DEF_LOAD_LAT   = 1;
   // Default stall counter width.
   localparam int DEF_CNT_W      = 32;

   // Forward select value meaning "take the operand from the register file".
   localparam int FWD_SEL_REGFILE = 0;

   // Tracker entry field widths: {v, rd, we, ld}; rd uses the module's REG_AW.
   localparam int TRK_V_W  = 1;
   localparam int TRK_WE_W = 1;
   localparam int TRK_LD_W = 1;

   // Forward select width for a given number of forwarding stages.
   function automatic int fwd_sel_width(input int fwd_stages);
      return (fwd_stages < 1) ? 1 : $clog2(fwd_stages + 1);
   endfunction

endpackage

// File: rtl/hazard_forward_unit_src_match.sv
// Per-source matcher: compares one EX source and one ID source against the
// in-flight writer tracker. Produces the EX forward select (youngest producer
// wins), the ID load-use hit, and a flag for a load forwarded too early.
module hfu_src_match
   import hazard_forward_unit_pkg::*;
#(
   parameter int REG_AW     = DEF_REG_AW,
   parameter int FWD_STAGES = DEF_FWD_STAGES,
   parameter int LOAD_LAT   = DEF_LOAD_LAT,
   parameter int SEL_W      = fwd_sel_width(DEF_FWD_STAGES)
) (
   input  logic [REG_AW-1:0]                 ex_addr,
   input  logic [REG_AW-1:0]                 id_addr,
   input  logic                              id_used,
   input  logic [FWD_STAGES:0]               trk_v,
   input  logic [FWD_STAGES:0]               trk_we,
   input  logic [FWD_STAGES:0]               trk_ld,
   input  logic [FWD_STAGES:0][REG_AW-1:0]   trk_rd,
   output logic [SEL_W-1:0]                  fwd_sel,
   output logic                              load_hit,
   output logic                              ex_ld_early
);

   // EX operand only ever looks at post-EX slots; ID only at slots younger than LOAD_LAT.
   logic [FWD_STAGES:1] ex_hit;
   logic [LOAD_LAT-1:0] id_hit;

   // Load flags of slots old enough to forward are never needed here.
   logic unused_ld;
   assign unused_ld = ^trk_ld[FWD_STAGES:LOAD_LAT+1];

   // Slot-by-slot address match; x0 writers never match anything.
   always_comb begin
      ex_hit = '0;
      id_hit = '0;
      for (int k = 1; k <= FWD_STAGES; k++) begin
         ex_hit[k] = trk_v[k] && trk_we[k] && (trk_rd[k] == ex_addr) && (ex_addr != '0);
      end
      for (int j = 0; j < LOAD_LAT; j++) begin
         id_hit[j] = trk_v[j] && trk_we[j] && (trk_rd[j] == id_addr) && (id_addr != '0);
      end
   end

   // Priority select: scan oldest to youngest so the youngest match is written last.
   always_comb begin
      fwd_sel = SEL_W'(FWD_SEL_REGFILE);
      for (int k = FWD_STAGES; k >= 1; k--) begin
         if (ex_hit[k]) begin
            fwd_sel = SEL_W'(k);
         end
      end
   end

   // Load-use hit: an actually-read ID source depends on a load still inside its latency window.
   always_comb begin
      load_hit = 1'b0;
      for (int j = 0; j < LOAD_LAT; j++) begin
         if (id_used && id_hit[j] && trk_ld[j]) begin
            load_hit = 1'b1;
         end
      end
   end

   // A valid EX instruction forwarding from a load whose data is not ready yet.
   always_comb begin
      ex_ld_early = 1'b0;
      for (int k = 1; k <= LOAD_LAT; k++) begin
         if (trk_v[0] && ex_hit[k] && trk_ld[k]) begin
            ex_ld_early = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding and load-use hazard unit for the RV32 pipeline.
// Shadows in-flight writers (slot 0 = EX, slots 1..FWD_STAGES = post-EX),
// drives per-source EX forward selects, the ID load-use stall and a
// saturating stall-cycle counter.
//
// Issue handshake: iss_valid is the ID-side valid, !stall is the ready.
// An instruction is accepted into EX on a rising edge where
// iss_valid && !stall && !flush; otherwise a bubble (v=0) enters slot 0.
// iss_* may change freely while not accepted. flush overrides stall.
module hazard_forward_unit
   import hazard_forward_unit_pkg::*;
#(
   parameter int REG_AW     = DEF_REG_AW,
   parameter int NUM_SRC    = DEF_NUM_SRC,
   parameter int FWD_STAGES = DEF_FWD_STAGES,
   parameter int LOAD_LAT   = DEF_LOAD_LAT,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         flush,
   input  logic                                         iss_valid,
   input  logic [REG_AW-1:0]                            iss_rd,
   input  logic                                         iss_we,
   input  logic                                         iss_is_load,
   input  logic [NUM_SRC*REG_AW-1:0]                    id_rs,
   input  logic [NUM_SRC-1:0]                           id_rs_used,
   input  logic [NUM_SRC*REG_AW-1:0]                    ex_rs,
   output logic [NUM_SRC*fwd_sel_width(FWD_STAGES)-1:0] fwd_sel,
   output logic                                         stall,
   output logic [CNT_W-1:0]                             stall_count
);

   localparam int SEL_W = fwd_sel_width(FWD_STAGES);

   // Tracker: one {v, rd, we, ld} entry per slot.
   logic [FWD_STAGES:0]             trk_v_q,  trk_v_d;
   logic [FWD_STAGES:0]             trk_we_q, trk_we_d;
   logic [FWD_STAGES:0]             trk_ld_q, trk_ld_d;
   logic [FWD_STAGES:0][REG_AW-1:0] trk_rd_q, trk_rd_d;

   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic [NUM_SRC-1:0] load_hit;
   logic [NUM_SRC-1:0] ex_ld_early;
   logic               issue_fire;

   // One matcher per source operand.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      hfu_src_match #(
         .REG_AW     (REG_AW),
         .FWD_STAGES (FWD_STAGES),
         .LOAD_LAT   (LOAD_LAT),
         .SEL_W      (SEL_W)
      ) u_src_match (
         .ex_addr     (ex_rs[i*REG_AW +: REG_AW]),
         .id_addr     (id_rs[i*REG_AW +: REG_AW]),
         .id_used     (id_rs_used[i]),
         .trk_v       (trk_v_q),
         .trk_we      (trk_we_q),
         .trk_ld      (trk_ld_q),
         .trk_rd      (trk_rd_q),
         .fwd_sel     (fwd_sel[i*SEL_W +: SEL_W]),
         .load_hit    (load_hit[i]),
         .ex_ld_early (ex_ld_early[i])
      );
   end

   // Stall when any read source needs a too-young load; a redirect kills the stall.
   always_comb begin
      stall      = iss_valid && !flush && (|load_hit);
      issue_fire = iss_valid && !stall && !flush;
   end

   // Tracker next state: age every slot by one, fill slot 0 with the accepted issue or a bubble.
   always_comb begin
      trk_v_d  = '0;
      trk_we_d = '0;
      trk_ld_d = '0;
      trk_rd_d = '0;
      for (int k = 1; k <= FWD_STAGES; k++) begin
         trk_v_d[k]  = trk_v_q[k-1];
         trk_we_d[k] = trk_we_q[k-1];
         trk_ld_d[k] = trk_ld_q[k-1];
         trk_rd_d[k] = trk_rd_q[k-1];
      end
      if (issue_fire) begin
         trk_v_d[0]  = 1'b1;
         trk_we_d[0] = iss_we;
         trk_ld_d[0] = iss_is_load;
         trk_rd_d[0] = iss_rd;
      end
   end

   // Stall counter next state: count stall cycles, stick at all-ones.
   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
         stall_count_d = stall_count_q + 1'b1;
      end
   end

   // Tracker and counter registers; reset empties the tracker so stall drops at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trk_v_q       <= '0;
         trk_we_q      <= '0;
         trk_ld_q      <= '0;
         trk_rd_q      <= '0;
         stall_count_q <= '0;
      end else begin
         trk_v_q       <= trk_v_d;
         trk_we_q      <= trk_we_d;
         trk_ld_q      <= trk_ld_d;
         trk_rd_q      <= trk_rd_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

`ifndef SYNTHESIS
   // A load inside its latency window must never be a forwarding source for EX.
   always @(posedge clk) begin
      if (!rst) begin
         assert (ex_ld_early == '0)
            else $error("hazard_forward_unit: EX forwards from a load before its data is ready");
      end
   end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Testbench for hazard_forward_unit: directed scenarios plus randomized
// issue traffic checked against an age-based model of in-flight writers.
module tb_hazard_forward_unit;

   localparam int A_FWD = 2;
   localparam int A_LL  = 1;

   // Clock / reset
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: default parameters
   logic        flush, iss_valid, iss_we, iss_is_load, stall;
   logic [4:0]  iss_rd;
   logic [9:0]  id_rs, ex_rs;
   logic [1:0]  id_rs_used;
   logic [3:0]  fwd_sel;
   logic [31:0] stall_count;

   hazard_forward_unit u_dut_a (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .iss_valid   (iss_valid),
      .iss_rd      (iss_rd),
      .iss_we      (iss_we),
      .iss_is_load (iss_is_load),
      .id_rs       (id_rs),
      .id_rs_used  (id_rs_used),
      .ex_rs       (ex_rs),
      .fwd_sel     (fwd_sel),
      .stall       (stall),
      .stall_count (stall_count)
   );

   // DUT B: longer load latency, 4-bit counter
   logic        b_flush, b_iss_valid, b_iss_we, b_iss_is_load, b_stall;
   logic [4:0]  b_iss_rd;
   logic [9:0]  b_id_rs, b_ex_rs;
   logic [1:0]  b_id_rs_used;
   logic [3:0]  b_fwd_sel;
   logic [3:0]  b_stall_count;

   hazard_forward_unit #(
      .FWD_STAGES (3),
      .LOAD_LAT   (2),
      .CNT_W      (4)
   ) u_dut_b (
      .clk         (clk),
      .rst         (rst),
      .flush       (b_flush),
      .iss_valid   (b_iss_valid),
      .iss_rd      (b_iss_rd),
      .iss_we      (b_iss_we),
      .iss_is_load (b_iss_is_load),
      .id_rs       (b_id_rs),
      .id_rs_used  (b_id_rs_used),
      .ex_rs       (b_ex_rs),
      .fwd_sel     (b_fwd_sel),
      .stall       (b_stall),
      .stall_count (b_stall_count)
   );

   // Scoreboard counters
   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model for DUT A: list of in-flight register writers with their age
   // in cycles since entering EX (age 0 = in EX).
   typedef struct {
      logic [4:0] rd;
      bit         ld;
      int         age;
   } wr_t;

   wr_t     infl[$];
   longint  exp_cnt;

   // Youngest post-EX writer of r, as its age; 0 = read the register file.
   function automatic int m_fwd(input logic [4:0] r);
      int best;
      best = 0;
      if (r == 5'd0) return 0;
      foreach (infl[n]) begin
         if (infl[n].rd == r && infl[n].age >= 1 && (best == 0 || infl[n].age < best)) best = infl[n].age;
      end
      return best;
   endfunction

   // ID must wait if a read source is produced by a load younger than A_LL cycles.
   function automatic bit m_stall();
      logic [4:0] r;
      if (!iss_valid || flush) return 1'b0;
      for (int i = 0; i < 2; i++) begin
         r = id_rs[i*5 +: 5];
         if (id_rs_used[i] && r != 5'd0) begin
            foreach (infl[n]) begin
               if (infl[n].ld && infl[n].rd == r && infl[n].age < A_LL) return 1'b1;
            end
         end
      end
      return 1'b0;
   endfunction

   // Driver tasks
   task automatic set_id(input bit v, input logic [4:0] rd, input bit we, input bit ld,
                         input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
      iss_valid   = v;
      iss_rd      = rd;
      iss_we      = we;
      iss_is_load = ld;
      id_rs       = {rs1, rs0};
      id_rs_used  = used;
   endtask

   task automatic b_set(input bit v, input logic [4:0] rd, input bit we, input bit ld,
                        input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
      b_iss_valid   = v;
      b_iss_rd      = rd;
      b_iss_we      = we;
      b_iss_is_load = ld;
      b_id_rs       = {rs1, rs0};
      b_id_rs_used  = used;
   endtask

   // One clock of DUT A; the model ages its writers and the EX sources follow the accepted issue.
   task automatic step_a();
      bit         acc, stl, we, ld;
      logic [4:0] rd;
      logic [9:0] nx;
      stl = m_stall();
      acc = iss_valid && !flush && !stl;
      we  = iss_we;
      ld  = iss_is_load;
      rd  = iss_rd;
      nx  = {id_rs_used[1] ? id_rs[9:5] : 5'd0, id_rs_used[0] ? id_rs[4:0] : 5'd0};
      @(posedge clk);
      #1;
      foreach (infl[n]) infl[n].age++;
      for (int n = infl.size() - 1; n >= 0; n--) begin
         if (infl[n].age > A_FWD) infl.delete(n);
      end
      if (acc && we) infl.push_back('{rd: rd, ld: ld, age: 0});
      if (stl && exp_cnt < 64'h0000_0000_FFFF_FFFF) exp_cnt++;
      if (acc) ex_rs = nx;
   endtask

   task automatic step_b();
      @(posedge clk);
      #1;
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
      $fatal(1, "simulation timeout");
   end

   // Stimulus
   initial begin
      rst     = 1'b1;
      flush   = 1'b0;
      ex_rs   = '0;
      exp_cnt = 0;
      set_id(0, 0, 0, 0, 0, 0, 2'b00);
      b_flush = 1'b0;
      b_ex_rs = '0;
      b_set(0, 0, 0, 0, 0, 0, 2'b00);

      // Reset state
      #3;
      chk("rst_fwd_a", fwd_sel, 0);
      chk("rst_stall_a", stall, 0);
      chk("rst_cnt_a", stall_count, 0);
      chk("rst_cnt_b", b_stall_count, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Writer x5 then a reader of x5: slot 1, then slot 2, then regfile
      set_id(1, 5, 1, 0, 1, 2, 2'b11);
      #2 chk("t1_no_stall", stall, 0);
      step_a();
      set_id(1, 8, 1, 0, 5, 3, 2'b11);
      step_a();
      set_id(0, 0, 0, 0, 0, 0, 2'b00);
      #2 chk("t1_fwd_slot1", fwd_sel[1:0], 1);
      chk("t1_fwd_src1", fwd_sel[3:2], 0);
      step_a();
      #2 chk("t1_fwd_slot2", fwd_sel[1:0], 2);
      step_a();
      #2 chk("t1_fwd_regfile", fwd_sel[1:0], 0);

      // Back-to-back writers of x5: youngest wins on both sources
      set_id(1, 5, 1, 0, 0, 0, 2'b00);
      step_a();
      step_a();
      set_id(1, 9, 1, 0, 5, 5, 2'b11);
      step_a();
      set_id(0, 0, 0, 0, 0, 0, 2'b00);
      #2 chk("t2_youngest", fwd_sel, 4'b0101);

      // lw x6 then a consumer of x6: one stall cycle, then forward from slot 2
      set_id(1, 6, 1, 1, 0, 0, 2'b00);
      step_a();
      set_id(1, 10, 1, 0, 6, 0, 2'b01);
      #2 chk("t3_stall", stall, 1);
      step_a();
      #2 chk("t3_stall_once", stall, 0);
      chk("t3_cnt", stall_count, 1);
      step_a();
      set_id(0, 0, 0, 0, 0, 0, 2'b00);
      #2 chk("t3_fwd_load", fwd_sel[1:0], 2);

      // x0 writer never forwards; unused source never stalls; x0 load never stalls
      set_id(1, 0, 1, 0, 0, 0, 2'b00);
      step_a();
      set_id(1, 11, 1, 0, 0, 0, 2'b11);
      step_a();
      set_id(0, 0, 0, 0, 0, 0, 2'b00);
      #2 chk("t5_x0_fwd", fwd_sel, 0);
      set_id(1, 9, 1, 1, 0, 0, 2'b00);
      step_a();
      set_id(1, 12, 1, 0, 9, 9, 2'b00);
      #2 chk("t5_unused_stall", stall, 0);
      step_a();
      set_id(1, 0, 1, 1, 0, 0, 2'b00);
      step_a();
      set_id(1, 13, 1, 0, 0, 0, 2'b11);
      #2 chk("t5_x0_load_stall", stall, 0);
      step_a();

      // Load-use with a same-cycle flush: no stall, not counted, consumer killed
      set_id(1, 6, 1, 1, 0, 0, 2'b00);
      step_a();
      set_id(1, 10, 1, 0, 6, 6, 2'b11);
      flush = 1'b1;
      #2 chk("t6_flush_stall", stall, 0);
      step_a();
      flush = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 2'b00);
      #2 chk("t6_flush_cnt", stall_count, 1);
      step_a();
      ex_rs = {5'd10, 5'd10};
      #2 chk("t6_killed_fwd", fwd_sel, 0);

      // Reset mid-stream while stalling and forwarding
      set_id(1, 5, 1, 0, 0, 0, 2'b00);
      step_a();
      set_id(1, 6, 1, 1, 5, 0, 2'b01);
      step_a();
      set_id(1, 10, 1, 0, 6, 0, 2'b01);
      #2 chk("t6_pre_rst_stall", stall, 1);
      chk("t6_pre_rst_fwd", fwd_sel[1:0], 1);
      chk("t6_pre_rst_cnt", stall_count, 1);
      rst = 1'b1;
      #1 chk("t6_rst_stall", stall, 0);
      chk("t6_rst_fwd", fwd_sel, 0);
      chk("t6_rst_cnt", stall_count, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 2'b00);
      ex_rs = '0;
      infl.delete();
      exp_cnt = 0;

      // DUT B: LOAD_LAT=2 gives two stall cycles, then forward from slot 3
      b_set(1, 7, 1, 1, 0, 0, 2'b00);
      step_b();
      b_set(1, 14, 1, 0, 7, 0, 2'b01);
      #2 chk("t4_stall_c1", b_stall, 1);
      step_b();
      #2 chk("t4_stall_c2", b_stall, 1);
      step_b();
      #2 chk("t4_stall_end", b_stall, 0);
      chk("t4_cnt", b_stall_count, 2);
      step_b();
      b_ex_rs = {5'd0, 5'd7};
      b_set(0, 0, 0, 0, 0, 0, 2'b00);
      #2 chk("t4_fwd_slot3", b_fwd_sel[1:0], 3);
      step_b();
      b_ex_rs = '0;

      // DUT B: self-dependent load stream stalls 2 of every 3 cycles; counter saturates at 15
      b_set(1, 7, 1, 1, 7, 0, 2'b01);
      for (int c = 0; c < 45; c++) step_b();
      chk("t6_cnt_sat", b_stall_count, 15);
      for (int c = 0; c < 9; c++) step_b();
      chk("t6_cnt_hold", b_stall_count, 15);
      b_set(0, 0, 0, 0, 0, 0, 2'b00);
      step_b();

      // Randomized traffic on DUT A against the model
      for (int c = 0; c < 400; c++) begin
         iss_valid   = ($urandom_range(0, 3) != 0);
         iss_rd      = 5'($urandom_range(0, 7));
         iss_we      = ($urandom_range(0, 4) != 0);
         iss_is_load = ($urandom_range(0, 2) == 0);
         id_rs       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         id_rs_used  = 2'($urandom_range(0, 3));
         flush       = ($urandom_range(0, 7) == 0);
         #2;
         chk("rnd_fwd0", fwd_sel[1:0], 64'(m_fwd(ex_rs[4:0])));
         chk("rnd_fwd1", fwd_sel[3:2], 64'(m_fwd(ex_rs[9:5])));
         chk("rnd_stall", stall, 64'(m_stall()));
         chk("rnd_cnt", stall_count, 64'(exp_cnt));
         step_a();
      end
      flush = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 2'b00);

      // Final report
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
